gpio_parallel_port: RTL and testbench

//   Parametrised memory-mapped bidirectional parallel port for the expansion headers (JP1/JP2).
//   Per-bit direction, atomic set/clear of outputs, synchronised inputs.
//   Per-bit rising/falling edge capture with a maskable level interrupt to the CPU.

---
 rtl/gpio_parallel_port.sv | 152 +++++++++++++++
 tb/tb_gpio_parallel_port.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_parallel_port.sv
// Memory-mapped bidirectional parallel port: per-bit direction, atomic set/clear,
// synchronised inputs and per-bit edge capture with a maskable level interrupt.
module gpio_parallel_port #(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RISE_RST    = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] bidir_port
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN = 3'd5;
  localparam logic [2:0] ADDR_SET     = 3'd6;
  localparam logic [2:0] ADDR_CLEAR   = 3'd7;

  localparam int         WARM_CYCLES = SYNC_STAGES + 1;
  localparam logic [2:0] WARM_DONE   = 3'(WARM_CYCLES);

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic [WIDTH-1:0] data_out, data_out_nxt;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture, capture_nxt;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;

  logic [WIDTH-1:0] sync_p [SYNC_STAGES];
  logic [WIDTH-1:0] prev_p;
  logic [2:0]       warm_cnt;

  logic             wr_en;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] rise, fall;
  logic [WIDTH-1:0] cap_set;
  logic [WIDTH-1:0] w1c;
  logic             detect_en;
  logic [31:0]      rd_mux;

  assign wr_en    = chipselect & ~write_n;
  assign wd       = writedata[WIDTH-1:0];
  assign sync_val = sync_p[SYNC_STAGES-1];

  // Pin drivers: each bit is released to high impedance unless configured as output.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
  end

  // Stage p0..pN: input synchroniser chain, then the previous-value register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      prev_p <= '0;
    end else begin
      sync_p[0] <= bidir_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      prev_p <= sync_val;
    end
  end

  // Hold off detection until the chain and prev register carry real pin values,
  // so a pin already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM_DONE) begin
      warm_cnt <= warm_cnt + 3'd1;
    end
  end

  assign detect_en = (warm_cnt == WARM_DONE);
  assign rise      = sync_val & ~prev_p;
  assign fall      = ~sync_val & prev_p;
  assign cap_set   = detect_en ? (~dir & ((rise & rise_en) | (fall & fall_en))) : '0;
  assign w1c       = (wr_en && (address == ADDR_CAPTURE)) ? wd : '0;

  // A fresh edge on the same cycle as a write-1-to-clear keeps the bit set.
  assign capture_nxt = (capture & ~w1c) | cap_set;

  always_comb begin
    data_out_nxt = data_out;
    if (wr_en) begin
      case (address)
        ADDR_DATA:  data_out_nxt = wd;
        ADDR_SET:   data_out_nxt = data_out | wd;
        ADDR_CLEAR: data_out_nxt = data_out & ~wd;
        default:    data_out_nxt = data_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      dir      <= '0;
      mask     <= '0;
      capture  <= '0;
      rise_en  <= RISE_RST;
      fall_en  <= '0;
    end else begin
      data_out <= data_out_nxt;
      capture  <= capture_nxt;
      if (wr_en && (address == ADDR_DIR))     dir     <= wd;
      if (wr_en && (address == ADDR_MASK))    mask    <= wd;
      if (wr_en && (address == ADDR_RISE_EN)) rise_en <= wd;
      if (wr_en && (address == ADDR_FALL_EN)) fall_en <= wd;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = zext(sync_val);
      ADDR_DIR:     rd_mux = zext(dir);
      ADDR_MASK:    rd_mux = zext(mask);
      ADDR_CAPTURE: rd_mux = zext(capture);
      ADDR_RISE_EN: rd_mux = zext(rise_en);
      ADDR_FALL_EN: rd_mux = zext(fall_en);
      default:      rd_mux = '0;
    endcase
  end

  // Read data is registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(capture & mask);

endmodule

// File: tb/tb_gpio_parallel_port.sv
// Directed self-checking bench for gpio_parallel_port; header pins carry pull-ups so
// an undriven (high-impedance) pin reads as 1.
module tb_gpio_parallel_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  tri1  [31:0] pins;

  logic [31:0] tb_oe;
  logic [31:0] tb_val;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 32; i++) begin : g_drv
    assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  gpio_parallel_port #(
    .WIDTH(32),
    .SYNC_STAGES(2),
    .RISE_RST(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq),
    .bidir_port(pins)
  );

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    if (readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h expected %h", readdata, 32'h0); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    checks++;
    @(negedge clk);
    reset_n = 1'b1;
    if (pins !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_pins_z: got %h expected %h", pins, 32'hFFFF_FFFF); end
    checks++;
    bus_read(3'd1, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_dir: got %h expected %h", rd, 32'h0); end
    checks++;
    bus_read(3'd2, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_mask: got %h expected %h", rd, 32'h0); end
    checks++;
    bus_read(3'd3, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_capture: got %h expected %h", rd, 32'h0); end
    checks++;
    bus_read(3'd4, rd);
    if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_rise_en: got %h expected %h", rd, 32'hFFFF_FFFF); end
    checks++;
    bus_read(3'd5, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_fall_en: got %h expected %h", rd, 32'h0); end
    checks++;
  endtask

  task automatic test_output_drive();
    tb_oe = 32'h0;
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_write(3'd0, 32'd1023);
    if (pins !== 32'h0000_03FF) begin errors++; $display("FAIL drive_1023: got %h expected %h", pins, 32'h0000_03FF); end
    checks++;
    bus_write(3'd0, 32'd1123);
    if (pins !== 32'h0000_0463) begin errors++; $display("FAIL drive_1123: got %h expected %h", pins, 32'h0000_0463); end
    checks++;
    bus_write(3'd0, 32'd1120);
    if (pins !== 32'h0000_0460) begin errors++; $display("FAIL drive_1120: got %h expected %h", pins, 32'h0000_0460); end
    checks++;
    repeat (2) @(negedge clk);
    bus_read(3'd0, rd);
    if (rd !== 32'h0000_0460) begin errors++; $display("FAIL data_readback: got %h expected %h", rd, 32'h0000_0460); end
    checks++;
  endtask

  task automatic test_set_clear();
    bus_write(3'd0, 32'h0000_000F);
    bus_write(3'd6, 32'h0000_00F0);
    if (pins !== 32'h0000_00FF) begin errors++; $display("FAIL set_pins: got %h expected %h", pins, 32'h0000_00FF); end
    checks++;
    bus_write(3'd7, 32'h0000_000C);
    if (pins !== 32'h0000_00F3) begin errors++; $display("FAIL clear_pins: got %h expected %h", pins, 32'h0000_00F3); end
    checks++;
    bus_read(3'd6, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL set_read: got %h expected %h", rd, 32'h0); end
    checks++;
    bus_read(3'd7, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL clear_read: got %h expected %h", rd, 32'h0); end
    checks++;
  endtask

  task automatic test_rise_irq();
    tb_val = 32'h0;
    tb_oe  = 32'hFFFF_FFFF;
    do_reset();
    bus_write(3'd2, 32'h1);
    repeat (4) @(negedge clk);
    tb_val[0] = 1'b1;
    repeat (2) @(negedge clk);
    if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early: got %b expected 0", irq); end
    checks++;
    @(negedge clk);
    if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq_set: got %b expected 1", irq); end
    checks++;
    bus_read(3'd3, rd);
    if (rd !== 32'h1) begin errors++; $display("FAIL rise_capture: got %h expected %h", rd, 32'h1); end
    checks++;
    bus_write(3'd3, 32'h1);
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", irq); end
    checks++;
    bus_read(3'd3, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL w1c_capture: got %h expected %h", rd, 32'h0); end
    checks++;
  endtask

  task automatic test_fall_race();
    bus_write(3'd5, 32'h2);
    tb_val[1] = 1'b1;
    repeat (4) @(negedge clk);
    bus_write(3'd3, 32'h2);
    bus_read(3'd3, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL race_preclear: got %h expected %h", rd, 32'h0); end
    checks++;
    tb_val[1] = 1'b0;
    repeat (2) @(negedge clk);
    bus_write(3'd3, 32'h2);
    bus_read(3'd3, rd);
    if (rd !== 32'h2) begin errors++; $display("FAIL race_set_wins: got %h expected %h", rd, 32'h2); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL race_irq_masked: got %b expected 0", irq); end
    checks++;
  endtask

  task automatic test_warmup_midreset();
    tb_val = 32'hFFFF_FFFF;
    tb_oe  = 32'hFFFF_FFFF;
    do_reset();
    repeat (6) @(negedge clk);
    bus_read(3'd3, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL warmup_capture: got %h expected %h", rd, 32'h0); end
    checks++;
    bus_write(3'd2, 32'h1);
    tb_oe[8] = 1'b0;
    bus_write(3'd1, 32'h0000_0100);
    if (pins[8] !== 1'b0) begin errors++; $display("FAIL pin8_driven: got %b expected 0", pins[8]); end
    checks++;
    tb_val[0] = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(3'd3, 32'hFFFF_FFFF);
    tb_val[0] = 1'b1;
    repeat (4) @(negedge clk);
    if (irq !== 1'b1) begin errors++; $display("FAIL midop_irq_before: got %b expected 1", irq); end
    checks++;
    #2;
    reset_n = 1'b0;
    #1;
    if (irq !== 1'b0) begin errors++; $display("FAIL async_irq: got %b expected 0", irq); end
    checks++;
    if (pins[8] !== 1'b1) begin errors++; $display("FAIL async_pin8_z: got %b expected 1", pins[8]); end
    checks++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    bus_read(3'd1, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL midop_dir: got %h expected %h", rd, 32'h0); end
    checks++;
    bus_read(3'd3, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL midop_capture: got %h expected %h", rd, 32'h0); end
    checks++;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    tb_oe      = 32'h0;
    tb_val     = 32'h0;
    test_reset();
    test_output_drive();
    test_set_clear();
    test_rise_irq();
    test_fall_race();
    test_warmup_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
